// File: rtl/sha2_msg_sched.sv
// sha2_msg_sched: SHA-256 / SHA-512 message schedule generator.
// A 16-word block is loaded into a sliding window. W0..W(ROUNDS-1) are then
// streamed out of the window head, and each new tail word is built from the
// sigma functions.
// Optional macro SHA2_MSG_SCHED_STALL_EN adds the wt_ready_i port for consumer
// backpressure. Without it the consumer is always ready and one word streams
// out per cycle.
module sha2_msg_sched #(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 msg_v_i,
    output logic                 msg_ready_o,
    input  logic [16*WORD_W-1:0] msg_i,
    output logic                 wt_v_o,
`ifdef SHA2_MSG_SCHED_STALL_EN
    input  logic                 wt_ready_i,
`endif
    output logic [WORD_W-1:0]    wt_o,
    output logic [6:0]           wt_idx_o,
    output logic                 wt_last_o
);

    // Reject unsupported configurations when the design is elaborated.
    generate
        if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
            $error("sha2_msg_sched: WORD_W must be 32 or 64");
        end
        if (ROUNDS != 64 && ROUNDS != 80) begin : g_bad_rounds
            $error("sha2_msg_sched: ROUNDS must be 64 or 80");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e            state_q;
    state_e            state_d;
    logic [WORD_W-1:0] w_q [16];
    logic [6:0]        t_q;
    logic              wt_ready;
    logic              accept;
    logic              handshake;
    logic              last_t;
    logic [WORD_W-1:0] w_new;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
        if (WORD_W == 32) return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
        else              return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
    endfunction

    function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
        if (WORD_W == 32) return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
        else              return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
    endfunction

`ifdef SHA2_MSG_SCHED_STALL_EN
    assign wt_ready = wt_ready_i;
`else
    assign wt_ready = 1'b1;
`endif

    assign msg_ready_o = (state_q == IDLE);
    assign wt_v_o      = (state_q == RUN);
    assign accept      = msg_v_i & msg_ready_o;
    assign handshake   = wt_v_o & wt_ready;
    assign last_t      = (t_q == 7'(ROUNDS - 1));
    assign wt_o        = w_q[0];
    assign wt_idx_o    = t_q;
    assign wt_last_o   = wt_v_o & last_t;
    assign w_new       = sigma1(w_q[14]) + w_q[9] + sigma0(w_q[1]) + w_q[0];

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state: accept a block in IDLE, return to IDLE after the last word is taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (msg_v_i) state_d = RUN;
            RUN:     if (wt_ready && last_t) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Window and round counter: load on accept, shift and extend on each handshake.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < 16; i++) w_q[i] <= '0;
            t_q <= '0;
        end else if (accept) begin
            for (int i = 0; i < 16; i++) w_q[i] <= msg_i[(15-i)*WORD_W +: WORD_W];
            t_q <= '0;
        end else if (handshake) begin
            for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
            w_q[15] <= w_new;
            t_q     <= t_q + 7'd1;
        end
    end

endmodule

// File: doc/sha2_msg_sched.md
SHA2_MSG_SCHED -- requirements
Module: sha2_msg_sched

Interface
- REQ-001 The module SHALL have parameter WORD_W, default 32, giving the schedule word width; the only legal values are 32 (SHA-256) and 64 (SHA-512).
- REQ-002 The module SHALL have parameter ROUNDS, default 64, giving the number of Wt words produced per block; the only legal values are 64 and 80.
- REQ-003 The module SHALL have port `clk_i`, input, 1 bit: the single clock; all state changes on its rising edge.
- REQ-004 The module SHALL have port `rst_n_i`, input, 1 bit: asynchronous, active-low reset.
- REQ-005 The module SHALL have port `msg_v_i`, input, 1 bit: message block valid.
- REQ-006 The module SHALL have port `msg_ready_o`, output, 1 bit: block can be accepted.
- REQ-007 The module SHALL have port `msg_i`, input, 16*WORD_W bits: message block; word 0 is in the most significant WORD_W bits.
- REQ-008 The module SHALL have port `wt_v_o`, output, 1 bit: `wt_o` is valid.
- REQ-009 The module SHALL have port `wt_ready_i`, input, 1 bit: consumer accepts Wt; present only when SHA2_MSG_SCHED_STALL_EN is defined.
- REQ-010 The module SHALL have port `wt_o`, output, WORD_W bits: the current schedule word Wt.
- REQ-011 The module SHALL have port `wt_idx_o`, output, 7 bits: the round index t of `wt_o`.
- REQ-012 The module SHALL have port `wt_last_o`, output, 1 bit: high when t == ROUNDS-1.

Function
- REQ-013 The module SHALL implement a two-state FSM with states IDLE and RUN.
- REQ-014 In IDLE, `msg_ready_o` SHALL be 1 and `wt_v_o` SHALL be 0; in RUN, `msg_ready_o` SHALL be 0 and `wt_v_o` SHALL be 1.
- REQ-015 A block SHALL be accepted on a cycle with `msg_v_i` & `msg_ready_o` high: the 16-word window W[0..15] loads from `msg_i`, t is set to 0, and the state goes to RUN.
- REQ-016 Latency SHALL be exactly 1 cycle: W0 appears on `wt_o`, with `wt_idx_o`=0, in the cycle after acceptance.
- REQ-017 `wt_o` SHALL always equal window entry W[0]; `wt_idx_o` SHALL equal t.
- REQ-018 An output handshake occurs when `wt_v_o` & `wt_ready_i` are high; on it the window SHALL shift down one entry, with new W[15] = σ1(W[14]) + W[9] + σ0(W[1]) + W[0] mod 2^WORD_W, and t SHALL increment.
- REQ-019 For WORD_W=32: σ0 = ROTR7 ^ ROTR18 ^ SHR3, and σ1 = ROTR17 ^ ROTR19 ^ SHR10.
- REQ-020 For WORD_W=64: σ0 = ROTR1 ^ ROTR8 ^ SHR7, and σ1 = ROTR19 ^ ROTR61 ^ SHR6.
- REQ-021 ROTR SHALL be a true rotate and SHR a logical shift with zero fill.
- REQ-022 Additions SHALL be WORD_W wide with carry-out discarded.
- REQ-023 When a handshake occurs with t == ROUNDS-1, the FSM SHALL return to IDLE and `wt_v_o` SHALL be 0 in the next cycle.
- REQ-024 A new block SHALL NOT be accepted in the same cycle as the last handshake; the back-to-back block period is ROUNDS+1 cycles.
- REQ-025 While `wt_v_o` is 1 and there is no handshake, `wt_o`, `wt_idx_o` and `wt_last_o` SHALL hold stable.
- REQ-026 `msg_v_i` asserted during RUN SHALL be ignored with no state change.
- REQ-027 An illegal WORD_W or ROUNDS value SHALL cause an elaboration-time error.

Reset
- REQ-028 Assertion of `rst_n_i`=0 SHALL, asynchronously, force state IDLE, t=0, all window entries 0, `wt_v_o`=0, `wt_o`=0, `wt_idx_o`=0 and `wt_last_o`=0.
- REQ-029 `msg_ready_o` SHALL read 1 during and after reset.
- REQ-030 Reset asserted mid-block SHALL abort the block; no further Wt of that block SHALL be produced after release.
- REQ-031 Reset release SHALL be synchronous to `clk_i`, and the first acceptance SHALL be possible on the first rising edge after release.

Configuration
- REQ-032 With macro SHA2_MSG_SCHED_STALL_EN defined, port `wt_ready_i` SHALL exist and gate every handshake, allowing arbitrary consumer backpressure.
- REQ-033 With SHA2_MSG_SCHED_STALL_EN undefined, port `wt_ready_i` SHALL be absent and treated internally as constant 1; Wt then streams one word per cycle, and a block completes exactly ROUNDS cycles after its first Wt.

Verification
- REQ-034 Scenario (WORD_W=32): block "abc" padded (W0=0x61626380, W1..W14=0, W15=0x00000018) -> Wt stream shall show W16=0x61626380 and W17=0x000F0000, and all 64 Wt shall match the FIPS 180-4 reference model.
- REQ-035 Scenario: all-zero block -> 64 Wt, all 0x00000000; `wt_last_o` shall be high only at `wt_idx_o`=63; `msg_ready_o` shall return to 1 one cycle later.
- REQ-036 Scenario (WORD_W=64, ROUNDS=80): padded "abc" block -> 80 Wt shall match the SHA-512 reference model, with W0=0x6162638000000000.
- REQ-037 Scenario (STALL_EN): `wt_ready_i` randomly low 50% of cycles -> the Wt sequence shall be identical to the no-stall run, and outputs shall be stable while stalled.
- REQ-038 Scenario: `rst_n_i` pulsed low at t=20 -> outputs shall be 0 immediately; after release, a new zero block shall produce `wt_idx_o` 0..63 correctly.
- REQ-039 Scenario: `msg_v_i` held high continuously -> blocks shall be accepted only in IDLE, every ROUNDS+1 cycles; `msg_v_i` during RUN shall not corrupt the stream.
